// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing RISC-V instructions over a
// shared ALU and a unified instruction/data memory. Drives the datapath muxes,
// register enables and the memory request/write strobes.
// Debug state encoding on `state`:
//   0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMREAD, 4 MEMWB, 5 MEMWRITE,
//   6 EXECUTER, 7 EXECUTEI, 8 ALUWB, 9 BEQ, 10 JAL, 11 ERROR
module multicycle_control_unit #(
    parameter logic MEM_WAIT_EN     = 1'b1,
    parameter logic TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opCode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       mem_req,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        ERROR    = 4'd11
    } state_t;

    state_t     cur, nxt;
    logic       rdy;
    logic       pc_update, branch, irw, regw, memw, req, ill;
    logic [1:0] alu_op;

    // With waiting disabled every memory access completes in one cycle.
    assign rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

    // State register; reset aborts whatever instruction is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur <= FETCH;
        else       cur <= nxt;
    end

    // Next state and per-state control (Moore, except the ready-qualified fetch strobes).
    always_comb begin
        nxt       = cur;
        pc_update = 1'b0;
        branch    = 1'b0;
        irw       = 1'b0;
        regw      = 1'b0;
        memw      = 1'b0;
        req       = 1'b0;
        ill       = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = 2'b00;
        case (cur)
            FETCH: begin
                req       = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                irw       = rdy;
                pc_update = rdy;
                if (rdy) nxt = DECODE;
            end
            DECODE: begin
                // ALU precomputes OldPC + Imm as the branch target
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (opCode)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_R:         nxt = EXECUTER;
                    OP_I:         nxt = EXECUTEI;
                    OP_BEQ:       nxt = BEQ;
                    OP_JAL:       nxt = JAL;
                    default:      nxt = TRAP_ON_ILLEGAL ? ERROR : FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                nxt     = (opCode == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                req    = 1'b1;
                if (rdy) nxt = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                regw      = 1'b1;
                nxt       = FETCH;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                req    = 1'b1;
                memw   = 1'b1;
                if (rdy) nxt = FETCH;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
                nxt     = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
                nxt     = ALUWB;
            end
            ALUWB: begin
                regw = 1'b1;
                nxt  = FETCH;
            end
            BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
                nxt     = FETCH;
            end
            JAL: begin
                // ALU forms OldPC + 4 for the link; PC takes the DECODE target
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
                nxt       = ALUWB;
            end
            ERROR: begin
                ill = 1'b1;
                nxt = ERROR;
            end
            default: nxt = FETCH;
        endcase
    end

    // Immediate format follows the opcode regardless of state.
    always_comb begin
        ImmSrc = 2'b00;
        case (opCode)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // ALU operation; funct7[5] only selects sub for R-type so addi never subtracts.
    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            default: begin
                case (funct3)
                    3'b000:  ALUControl = (opCode[5] & funct7[5]) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b100:  ALUControl = 3'b100;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
        endcase
    end

    // Strobes are held off for as long as reset is asserted.
    assign PCWrite  = ~reset & (pc_update | (branch & zero));
    assign IRWrite  = ~reset & irw;
    assign RegWrite = ~reset & regw;
    assign MemWrite = ~reset & memw;
    assign mem_req  = ~reset & req;
    assign illegal  = ~reset & ill;
    assign state    = cur;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit. Two instances share stimulus:
//   dut_a: MEM_WAIT_EN=1, TRAP_ON_ILLEGAL=1
//   dut_b: MEM_WAIT_EN=0, TRAP_ON_ILLEGAL=0
// A sequence model (per-opcode step list) predicts every output each cycle;
// directed literal checks pin the model against hand-worked expectations.
// Compared vector order: PCWrite, AdrSrc, MemWrite, mem_req, IRWrite, RegWrite,
// ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, state.
module tb_multicycle_control_unit;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BQ_OP = 7'b1100011, JAL_OP = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    // debug state codes documented in the design header
    localparam logic [3:0] S_F = 4'd0, S_D = 4'd1, S_MA = 4'd2, S_MR = 4'd3, S_MWB = 4'd4;
    localparam logic [3:0] S_MW = 4'd5, S_XR = 4'd6, S_XI = 4'd7, S_AW = 4'd8;
    localparam logic [3:0] S_BQ = 4'd9, S_J = 4'd10, S_ER = 4'd11;

    logic       clk = 1'b0, reset = 1'b1;
    logic [6:0] opCode = LW;
    logic [2:0] funct3 = 3'b000;
    logic [6:0] funct7 = 7'b0;
    logic       zero = 1'b0, mem_ready = 1'b0;

    logic       PCWrite_a, AdrSrc_a, MemWrite_a, mem_req_a, IRWrite_a, RegWrite_a, illegal_a;
    logic [1:0] ResultSrc_a, ALUSrcA_a, ALUSrcB_a, ImmSrc_a;
    logic [2:0] ALUControl_a;
    logic [3:0] state_a;
    logic       PCWrite_b, AdrSrc_b, MemWrite_b, mem_req_b, IRWrite_b, RegWrite_b, illegal_b;
    logic [1:0] ResultSrc_b, ALUSrcA_b, ALUSrcB_b, ImmSrc_b;
    logic [2:0] ALUControl_b;
    logic [3:0] state_b;

    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.MEM_WAIT_EN(1'b1), .TRAP_ON_ILLEGAL(1'b1)) dut_a (
        .clk(clk), .reset(reset), .opCode(opCode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite_a), .AdrSrc(AdrSrc_a),
        .MemWrite(MemWrite_a), .mem_req(mem_req_a), .IRWrite(IRWrite_a), .RegWrite(RegWrite_a),
        .ResultSrc(ResultSrc_a), .ALUSrcA(ALUSrcA_a), .ALUSrcB(ALUSrcB_a), .ImmSrc(ImmSrc_a),
        .ALUControl(ALUControl_a), .illegal(illegal_a), .state(state_a));

    multicycle_control_unit #(.MEM_WAIT_EN(1'b0), .TRAP_ON_ILLEGAL(1'b0)) dut_b (
        .clk(clk), .reset(reset), .opCode(opCode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite_b), .AdrSrc(AdrSrc_b),
        .MemWrite(MemWrite_b), .mem_req(mem_req_b), .IRWrite(IRWrite_b), .RegWrite(RegWrite_b),
        .ResultSrc(ResultSrc_b), .ALUSrcA(ALUSrcA_b), .ALUSrcB(ALUSrcB_b), .ImmSrc(ImmSrc_b),
        .ALUControl(ALUControl_b), .illegal(illegal_b), .state(state_b));

    logic [21:0] act_a, act_b;
    assign act_a = {PCWrite_a, AdrSrc_a, MemWrite_a, mem_req_a, IRWrite_a, RegWrite_a,
                    ResultSrc_a, ALUSrcA_a, ALUSrcB_a, ImmSrc_a, ALUControl_a, illegal_a, state_a};
    assign act_b = {PCWrite_b, AdrSrc_b, MemWrite_b, mem_req_b, IRWrite_b, RegWrite_b,
                    ResultSrc_b, ALUSrcA_b, ALUSrcB_b, ImmSrc_b, ALUControl_b, illegal_b, state_b};

    // ---------------- model ----------------
    // After FETCH and DECODE an instruction walks a fixed list of steps.
    function automatic logic [3:0] plan_at(input logic [6:0] op, input bit trap, input int k);
        logic [3:0] p [3];
        p = '{S_F, S_F, S_F};
        case (op)
            LW:      p = '{S_MA, S_MR, S_MWB};
            SW:      p = '{S_MA, S_MW, S_F};
            RT:      p = '{S_XR, S_AW, S_F};
            IT:      p = '{S_XI, S_AW, S_F};
            BQ_OP:   p = '{S_BQ, S_F, S_F};
            JAL_OP:  p = '{S_J, S_AW, S_F};
            default: p = '{(trap ? S_ER : S_F), S_F, S_F};
        endcase
        if (k >= 0 && k < 3) return p[k];
        return S_F;
    endfunction

    function automatic logic [21:0] exp_vec(input logic [3:0] st, input logic [6:0] op,
                                            input logic [2:0] f3, input logic [6:0] f7,
                                            input bit z, input bit rdy, input bit rst);
        bit pcu, br, adr, mw, req, irw, rw, ill, pcw;
        logic [1:0] res, sa, sb, aop, imm;
        logic [2:0] alu;
        {pcu, br, adr, mw, req, irw, rw, ill} = '0;
        res = 2'd0; sa = 2'd0; sb = 2'd0; aop = 2'd0;
        case (st)
            S_F:   begin req = 1; sb = 2; res = 2; irw = rdy; pcu = rdy; end
            S_D:   begin sa = 1; sb = 1; end
            S_MA:  begin sa = 2; sb = 1; end
            S_MR:  begin adr = 1; req = 1; end
            S_MWB: begin res = 1; rw = 1; end
            S_MW:  begin adr = 1; req = 1; mw = 1; end
            S_XR:  begin sa = 2; aop = 2; end
            S_XI:  begin sa = 2; sb = 1; aop = 2; end
            S_AW:  rw = 1;
            S_BQ:  begin sa = 2; aop = 1; br = 1; end
            S_J:   begin sa = 1; sb = 2; pcu = 1; end
            S_ER:  ill = 1;
            default: ;
        endcase
        pcw = pcu | (br & z);
        if (rst) begin pcw = 0; irw = 0; rw = 0; mw = 0; req = 0; ill = 0; end
        case (op)
            SW:      imm = 2'd1;
            BQ_OP:   imm = 2'd2;
            JAL_OP:  imm = 2'd3;
            default: imm = 2'd0;
        endcase
        if (aop == 0)      alu = 3'b000;
        else if (aop == 1) alu = 3'b001;
        else case (f3)
            3'b000:  alu = (op[5] && f7[5]) ? 3'b001 : 3'b000;
            3'b010:  alu = 3'b101;
            3'b100:  alu = 3'b100;
            3'b110:  alu = 3'b011;
            3'b111:  alu = 3'b010;
            default: alu = 3'b000;
        endcase
        return {pcw, adr, mw, req, irw, rw, res, sa, sb, imm, alu, ill, st};
    endfunction

    // model index 0 mirrors dut_a's parameters (wait, trap), index 1 dut_b's (no wait, no trap)
    logic [3:0] mcur [2] = '{S_F, S_F};
    int         mk   [2] = '{0, 0};

    always @(posedge clk or posedge reset) begin
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                mcur[m] <= S_F;
                mk[m]   <= 0;
            end else if (mcur[m] == S_ER) begin
                mcur[m] <= S_ER;
            end else if ((mcur[m] == S_F || mcur[m] == S_MR || mcur[m] == S_MW) &&
                         !(mem_ready || m != 0)) begin
                mcur[m] <= mcur[m];
            end else if (mcur[m] == S_F) begin
                mcur[m] <= S_D;
                mk[m]   <= 0;
            end else begin
                mcur[m] <= plan_at(opCode, (m == 0), mk[m]);
                mk[m]   <= mk[m] + 1;
            end
        end
    end

    task automatic model_cmp();
        logic [21:0] e, a;
        for (int m = 0; m < 2; m++) begin
            e = exp_vec(mcur[m], opCode, funct3, funct7, zero, (mem_ready || m != 0), reset);
            a = (m == 0) ? act_a : act_b;
            n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL model_dut%0d t=%0t: got %h expected %h", m, $time, a, e);
            end
        end
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // every cycle passes through neg(), so the model is compared on every cycle
    task automatic neg(); @(negedge clk); model_cmp(); endtask
    task automatic pos(); @(posedge clk); #1; endtask
    task automatic do_reset(); reset = 1'b1; neg(); pos(); reset = 1'b0; endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [3:0] e [7];
        logic [6:0] t_op [6];
        logic [2:0] t_f3 [6];
        logic [6:0] t_f7 [6];
        logic [2:0] t_alu [6];

        // reset state
        mem_ready = 1'b1;
        neg();
        lit("rst_mem_req", mem_req_a, 0);
        lit("rst_irwrite", IRWrite_a, 0);
        lit("rst_pcwrite", PCWrite_a, 0);
        lit("rst_state", state_a, S_F);
        lit("rst_alusrcb", ALUSrcB_a, 2);
        lit("rst_resultsrc", ResultSrc_a, 2);
        lit("rst_illegal", illegal_a, 0);
        pos();

        // lw, zero-wait: 5 cycles, RegWrite only in the last
        opCode = LW; funct3 = 3'b010; funct7 = 7'b0; zero = 1'b0; mem_ready = 1'b1;
        do_reset();
        e = '{S_F, S_D, S_MA, S_MR, S_MWB, S_F, S_F};
        for (int c = 0; c < 5; c++) begin
            neg();
            lit($sformatf("lw_state%0d", c), state_a, e[c]);
            lit($sformatf("lw_regwrite%0d", c), RegWrite_a, (c == 4) ? 1 : 0);
            if (c == 4) lit("lw_resultsrc", ResultSrc_a, 1);
            if (c == 0) lit("lw_immsrc", ImmSrc_a, 0);
            pos();
        end
        neg(); lit("lw_done_fetch", state_a, S_F); pos();

        // sw with 3 wait cycles in MEMWRITE: 7 cycles, MemWrite held 4 cycles
        opCode = SW; funct3 = 3'b010; mem_ready = 1'b1;
        do_reset();
        e = '{S_F, S_D, S_MA, S_MW, S_MW, S_MW, S_MW};
        for (int c = 0; c < 7; c++) begin
            mem_ready = !(c >= 3 && c <= 5);
            neg();
            lit($sformatf("sw_state%0d", c), state_a, e[c]);
            lit($sformatf("sw_memwrite%0d", c), MemWrite_a, (c >= 3) ? 1 : 0);
            lit($sformatf("sw_adrsrc%0d", c), AdrSrc_a, (c >= 3) ? 1 : 0);
            pos();
        end
        neg();
        lit("sw_done_fetch", state_a, S_F);
        lit("sw_immsrc", ImmSrc_a, 1);
        pos();

        // ALU decode in EXECUTE, 4-cycle latency each
        t_op  = '{RT, IT, RT, IT, RT, IT};
        t_f3  = '{3'b000, 3'b000, 3'b110, 3'b010, 3'b111, 3'b100};
        t_f7  = '{7'h20, 7'h20, 7'h00, 7'h00, 7'h00, 7'h20};
        t_alu = '{3'b001, 3'b000, 3'b011, 3'b101, 3'b010, 3'b100};
        for (int t = 0; t < 6; t++) begin
            opCode = t_op[t]; funct3 = t_f3[t]; funct7 = t_f7[t]; mem_ready = 1'b1;
            do_reset();
            for (int c = 0; c < 5; c++) begin
                neg();
                if (c == 2) begin
                    lit($sformatf("exec%0d_state", t), state_a, (t_op[t] == RT) ? S_XR : S_XI);
                    lit($sformatf("exec%0d_alucontrol", t), ALUControl_a, t_alu[t]);
                end
                if (c == 3) lit($sformatf("exec%0d_regwrite", t), RegWrite_a, 1);
                if (c == 4) lit($sformatf("exec%0d_done_fetch", t), state_a, S_F);
                pos();
            end
        end

        // beq: PCWrite follows zero in BEQ, 3 cycles either way
        for (int zz = 0; zz < 2; zz++) begin
            opCode = BQ_OP; funct3 = 3'b000; funct7 = 7'b0; zero = zz[0]; mem_ready = 1'b1;
            do_reset();
            neg(); pos();
            neg(); lit($sformatf("beq%0d_decode_pcwrite", zz), PCWrite_a, 0); pos();
            neg();
            lit($sformatf("beq%0d_state", zz), state_a, S_BQ);
            lit($sformatf("beq%0d_pcwrite", zz), PCWrite_a, zz);
            pos();
            neg(); lit($sformatf("beq%0d_done_fetch", zz), state_a, S_F); pos();
        end
        zero = 1'b0;

        // jal: PC update in JAL, link written in ALUWB
        opCode = JAL_OP; mem_ready = 1'b1;
        do_reset();
        neg(); pos();
        neg(); pos();
        neg();
        lit("jal_state", state_a, S_J);
        lit("jal_pcwrite", PCWrite_a, 1);
        lit("jal_immsrc", ImmSrc_a, 3);
        pos();
        neg(); lit("jal_wb_state", state_a, S_AW); lit("jal_regwrite", RegWrite_a, 1); pos();
        neg(); lit("jal_done_fetch", state_a, S_F); pos();

        // illegal opcode: dut_a traps, dut_b returns to FETCH
        opCode = BAD; mem_ready = 1'b1;
        do_reset();
        neg(); pos();
        neg(); pos();
        neg();
        lit("ill_notrap_fetch", state_b, S_F);
        lit("ill_trap_state", state_a, S_ER);
        pos();
        for (int i = 0; i < 10; i++) begin
            mem_ready = i[0];
            neg();
            lit($sformatf("ill_flag%0d", i), illegal_a, 1);
            lit($sformatf("ill_strobes%0d", i),
                {PCWrite_a, IRWrite_a, RegWrite_a, MemWrite_a, mem_req_a}, 0);
            pos();
        end

        // reset mid-MEMWRITE while memory is stalled
        opCode = SW; funct3 = 3'b010; mem_ready = 1'b1;
        do_reset();
        neg(); pos();
        neg(); pos();
        neg(); pos();
        mem_ready = 1'b0;
        neg();
        lit("rmw_memwrite_before", MemWrite_a, 1);
        #2 reset = 1'b1;
        #1;
        lit("rmw_memwrite_in_reset", MemWrite_a, 0);
        lit("rmw_state_in_reset", state_a, S_F);
        lit("rmw_mem_req_in_reset", mem_req_a, 0);
        pos();
        reset = 1'b0;
        neg(); lit("rmw_irwrite_wait", IRWrite_a, 0); lit("rmw_state_wait", state_a, S_F); pos();
        mem_ready = 1'b1;
        neg(); lit("rmw_irwrite", IRWrite_a, 1); lit("rmw_pcwrite", PCWrite_a, 1); pos();
        neg(); lit("rmw_decode", state_a, S_D); pos();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
